// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the command decoder.
// First-word-fall-through head register, occupancy count and sticky overrun flag.
module uart_rx_fifo #(
   parameter int size      = 8,
   parameter int addr_bits = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [size-1:0]      w_data,
   input  logic                 rd,
   input  logic                 clr_ovr,
   output logic [size-1:0]      r_data,
   output logic                 empty,
   output logic                 full,
   output logic [addr_bits:0]   count,
   output logic                 overrun
);

   localparam int DEPTH = 2 ** addr_bits;
   localparam logic [addr_bits-1:0] PTR_ONE    = addr_bits'(1'b1);
   localparam logic [addr_bits:0]   CNT_ONE    = (addr_bits + 1)'(1'b1);
   localparam logic [addr_bits:0]   CNT_ZERO   = (addr_bits + 1)'(1'b0);
   localparam logic [addr_bits:0]   FULL_COUNT = {1'b1, {addr_bits{1'b0}}};

   logic [size-1:0]      mem_r [0:DEPTH-1];
   logic [addr_bits-1:0] wptr_r;
   logic [addr_bits-1:0] rptr_r;
   logic [addr_bits:0]   count_r;
   logic                 empty_r;
   logic                 full_r;
   logic                 overrun_r;
   logic [size-1:0]      r_data_r;

   logic                 we_s;
   logic                 re_s;
   logic [addr_bits-1:0] wptr_n_s;
   logic [addr_bits-1:0] rptr_n_s;
   logic [addr_bits:0]   count_n_s;
   logic                 empty_n_s;
   logic                 full_n_s;
   logic                 overrun_n_s;
   logic [size-1:0]      head_n_s;

   // Next-state computation for pointers, occupancy, flags and head register
   always_comb begin
      we_s        = wr & (~full_r | rd);
      re_s        = rd & ~empty_r;
      wptr_n_s    = wptr_r;
      rptr_n_s    = rptr_r;
      count_n_s   = count_r;
      head_n_s    = {size{1'b0}};
      overrun_n_s = overrun_r;

      case ({we_s, re_s})
         2'b10: begin
            wptr_n_s  = wptr_r + PTR_ONE;
            count_n_s = count_r + CNT_ONE;
         end
         2'b01: begin
            rptr_n_s  = rptr_r + PTR_ONE;
            count_n_s = count_r - CNT_ONE;
         end
         2'b11: begin
            wptr_n_s  = wptr_r + PTR_ONE;
            rptr_n_s  = rptr_r + PTR_ONE;
         end
         default: begin
            count_n_s = count_r;
         end
      endcase

      empty_n_s = (count_n_s == CNT_ZERO);
      full_n_s  = (count_n_s == FULL_COUNT);

      // The byte being written this edge becomes the head when nothing older remains
      if (empty_n_s) begin
         head_n_s = {size{1'b0}};
      end else if (we_s && (wptr_r == rptr_n_s)) begin
         head_n_s = w_data;
      end else begin
         head_n_s = mem_r[rptr_n_s];
      end

      if (wr && full_r && !rd) begin
         overrun_n_s = 1'b1;
      end else if (clr_ovr) begin
         overrun_n_s = 1'b0;
      end else begin
         overrun_n_s = overrun_r;
      end
   end

   // Control state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_r    <= {addr_bits{1'b0}};
         rptr_r    <= {addr_bits{1'b0}};
         count_r   <= CNT_ZERO;
         empty_r   <= 1'b1;
         full_r    <= 1'b0;
         overrun_r <= 1'b0;
         r_data_r  <= {size{1'b0}};
      end else begin
         wptr_r    <= wptr_n_s;
         rptr_r    <= rptr_n_s;
         count_r   <= count_n_s;
         empty_r   <= empty_n_s;
         full_r    <= full_n_s;
         overrun_r <= overrun_n_s;
         r_data_r  <= head_n_s;
      end
   end

   // Storage array, deliberately without reset
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_r[wptr_r] <= w_data;
      end
   end

   assign r_data  = r_data_r;
   assign empty   = empty_r;
   assign full    = full_r;
   assign count   = count_r;
   assign overrun = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (depth 4, 8-bit data).
module tb_uart_rx_fifo;

   logic       clk;
   logic       reset;
   logic       wr;
   logic [7:0] w_data;
   logic       rd;
   logic       clr_ovr;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       overrun;

   int checks;
   int errors;

   uart_rx_fifo #(.size(8), .addr_bits(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .w_data  (w_data),
      .rd      (rd),
      .clr_ovr (clr_ovr),
      .r_data  (r_data),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr = w; w_data = d; rd = r; clr_ovr = c;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // reset held with random traffic
      for (int i = 0; i < 6; i++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         tick();
      end
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_overrun", overrun, 0);
      check("rst_rdata", r_data, 8'h00);

      drive(1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      tick();

      // first write visible after one edge
      drive(1'b1, 8'h3C, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("w1_rdata", r_data, 8'h3C);
      check("w1_count", count, 1);
      check("w1_empty", empty, 0);
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("pop1_empty", empty, 1);
      check("pop1_rdata", r_data, 8'h00);

      // fill to full
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0); tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("fill_full", full, 1);
      check("fill_count", count, 4);
      check("fill_head", r_data, 8'h01);

      // dropped write while full
      drive(1'b1, 8'hAA, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("ovr_count", count, 4);
      check("ovr_head", r_data, 8'h01);
      check("ovr_flag", overrun, 1);
      tick();
      check("ovr_sticky", overrun, 1);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("ovr_clr", overrun, 0);
      drive(1'b1, 8'hAB, 1'b0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("ovr_set_wins", overrun, 1);
      check("ovr_set_count", count, 4);
      drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("ovr_clr2", overrun, 0);

      // simultaneous write and pop while full
      check("simf_pre_head", r_data, 8'h01);
      drive(1'b1, 8'h55, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("simf_count", count, 4);
      check("simf_full", full, 1);
      check("simf_overrun", overrun, 0);
      check("simf_head", r_data, 8'h02);

      // drain, 0x55 last
      check("drain0", r_data, 8'h02);
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      check("drain_notfull", full, 0);
      check("drain1", r_data, 8'h03);
      tick();
      check("drain2", r_data, 8'h04);
      tick();
      check("drain3", r_data, 8'h55);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_empty", empty, 1);
      check("drain_rdata", r_data, 8'h00);
      check("drain_count", count, 0);

      // pop on empty ignored, write on empty accepted
      drive(1'b1, 8'h77, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("sime_count", count, 1);
      check("sime_rdata", r_data, 8'h77);
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("sime_empty", empty, 1);

      // wrap-around streaming at occupancy 2
      drive(1'b1, 8'h10, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
      for (int k = 0; k < 8; k++) begin
         check("wrap_head", r_data, 32'(8'h10 + k));
         drive(1'b1, 8'(8'h12 + k), 1'b1, 1'b0); tick();
         check("wrap_count", count, 2);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_tail0", r_data, 8'h18);
      tick();
      check("wrap_tail1", r_data, 8'h19);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("wrap_empty", empty, 1);

      // asynchronous reset between edges
      drive(1'b1, 8'hA1, 1'b0, 1'b0); tick();
      drive(1'b1, 8'hA2, 1'b0, 1'b0); tick();
      drive(1'b1, 8'hA3, 1'b0, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("mid_count", count, 3);
      #2;
      reset = 1'b0;
      #1;
      check("async_count", count, 0);
      check("async_empty", empty, 1);
      check("async_rdata", r_data, 8'h00);
      check("async_full", full, 0);
      tick();
      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      check("post_pop_count", count, 0);
      check("post_pop_empty", empty, 1);
      check("post_pop_rdata", r_data, 8'h00);
      check("post_pop_ovr", overrun, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
